// File: rtl/tl_sched_pkg.sv
// Shared encodings and helpers for the intersection phase scheduler.
package tl_sched_pkg;

  localparam int REMAIN_W = 7;

  typedef enum logic [1:0] {
    PH_NS_THRU = 2'd0,
    PH_NS_LEFT = 2'd1,
    PH_EW_THRU = 2'd2,
    PH_EW_LEFT = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_ALL_RED = 2'd3
  } state_e;

  // One-hot lamp mask for a phase number.
  function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
    return 4'b0001 << ph;
  endfunction

  // First requesting phase after cur, searched cur+1, cur+2, cur+3, cur.
  function automatic logic [1:0] rr_next(input logic [1:0] cur, input logic [3:0] req);
    logic [1:0] cand;
    logic [1:0] pick;
    logic       found;
    pick  = cur;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = cur + i[1:0];
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Divides sys_clk down to a one-cycle 1 s strobe.
// wrap is the combinational "counter at its last value" flag so the scheduler
// can update its state on the same edge that raises the registered tick.
module tl_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic wrap,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign wrap = (cnt == CW'(TICK_DIV - 1));

  // Free-running 0..TICK_DIV-1 counter; strobe registered on the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= CW'(0);
      tick <= 1'b0;
    end else if (wrap) begin
      cnt  <= CW'(0);
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tl_phase_scheduler.sv
// Demand-actuated round-robin phase scheduler for a four-approach intersection.
// Optional emergency preemption is compiled in with `define TL_PREEMPT_EN.
module tl_phase_scheduler
  import tl_sched_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 27,
  parameter int EXT       = 3,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [3:0]          demand_i,
`ifdef TL_PREEMPT_EN
  input  logic                preempt_i,
  input  logic [1:0]          preempt_phase_i,
`endif
  output logic [3:0]          green_o,
  output logic [3:0]          yellow_o,
  output logic [1:0]          state_o,
  output logic [1:0]          cur_phase_o,
  output logic [REMAIN_W-1:0] remain_o,
  output logic                tick_o
);

  localparam logic [REMAIN_W-1:0] ZERO_R = REMAIN_W'(0);
  localparam logic [REMAIN_W-1:0] ONE_R  = REMAIN_W'(1);
  localparam logic [REMAIN_W-1:0] MIN_R  = REMAIN_W'(MIN_GREEN);
  localparam logic [REMAIN_W-1:0] MAX_R  = REMAIN_W'(MAX_GREEN);
  localparam logic [REMAIN_W-1:0] EXT_R  = REMAIN_W'(EXT);
  localparam logic [REMAIN_W-1:0] YEL_R  = REMAIN_W'(YELLOW);
  localparam logic [REMAIN_W-1:0] AR_R   = REMAIN_W'(ALL_RED);
  localparam logic [REMAIN_W:0]   MAX_E  = (REMAIN_W+1)'(MAX_GREEN);

  state_e              state_q, state_n;
  logic [1:0]          phase_q, phase_n;
  logic [REMAIN_W-1:0] remain_q, remain_n;
  logic [REMAIN_W-1:0] elapsed_q, elapsed_n, elapsed_sat;
  logic [REMAIN_W:0]   elapsed_inc;
  logic [3:0]          demand_q, demand_n;
  logic [3:0]          green_q, yellow_q;
  logic [3:0]          green_mask, clear_mask;
  logic                tick_wrap;
  logic                other;
  logic                max_hit;
`ifdef TL_PREEMPT_EN
  logic                pre_q;
  logic                pre_fall;
`endif

  tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .wrap (tick_wrap),
    .tick (tick_o)
  );

  assign other       = |(demand_q & ~phase_onehot(phase_q));
  assign elapsed_inc = (REMAIN_W+1)'(elapsed_q) + (REMAIN_W+1)'(1);
  assign max_hit     = (elapsed_inc >= MAX_E);
  assign elapsed_sat = max_hit ? MAX_R : elapsed_inc[REMAIN_W-1:0];
`ifdef TL_PREEMPT_EN
  assign pre_fall    = pre_q & ~preempt_i;
`endif

  // Next interval, phase and countdown; GREEN/YELLOW/ALL_RED advance only on ticks.
  always_comb begin
    state_n   = state_q;
    phase_n   = phase_q;
    remain_n  = remain_q;
    elapsed_n = elapsed_q;
    case (state_q)
      ST_IDLE: begin
        if (demand_q != 4'b0000) begin
          state_n   = ST_GREEN;
          phase_n   = rr_next(phase_q, demand_q);
          remain_n  = MIN_R;
          elapsed_n = ZERO_R;
        end else begin
          remain_n  = ZERO_R;
        end
      end
      ST_GREEN: begin
        if (tick_wrap) begin
          elapsed_n = elapsed_sat;
          if (max_hit && other) begin
            state_n  = ST_YELLOW;
            remain_n = YEL_R;
          end else if (demand_i[phase_q] && (remain_q <= EXT_R) && !max_hit) begin
            remain_n = EXT_R;
          end else if (remain_q <= ONE_R) begin
            if (other) begin
              state_n  = ST_YELLOW;
              remain_n = YEL_R;
            end else begin
              remain_n = ZERO_R;
            end
          end else begin
            remain_n = remain_q - ONE_R;
          end
        end else begin
          remain_n = remain_q;
        end
      end
      ST_YELLOW: begin
        if (tick_wrap) begin
          if (remain_q == ONE_R) begin
            state_n  = ST_ALL_RED;
            remain_n = AR_R;
          end else begin
            remain_n = remain_q - ONE_R;
          end
        end else begin
          remain_n = remain_q;
        end
      end
      ST_ALL_RED: begin
        if (tick_wrap) begin
          if (remain_q == ONE_R) begin
            state_n  = ST_IDLE;
            remain_n = ZERO_R;
          end else begin
            remain_n = remain_q - ONE_R;
          end
        end else begin
          remain_n = remain_q;
        end
      end
      default: begin
        state_n  = ST_IDLE;
        remain_n = ZERO_R;
      end
    endcase
`ifdef TL_PREEMPT_EN
    // Preemption overrides the normal rules: clear a conflicting green at once,
    // hold the preempt phase green with a blank countdown, and restart on release.
    if (preempt_i && (state_q == ST_GREEN) && (phase_q != preempt_phase_i)) begin
      state_n  = ST_YELLOW;
      phase_n  = phase_q;
      remain_n = YEL_R;
    end else if (preempt_i && (state_q == ST_GREEN)) begin
      state_n   = ST_GREEN;
      phase_n   = phase_q;
      remain_n  = ZERO_R;
      elapsed_n = elapsed_q;
    end else if (preempt_i && (state_q == ST_IDLE)) begin
      state_n   = ST_GREEN;
      phase_n   = preempt_phase_i;
      remain_n  = ZERO_R;
      elapsed_n = ZERO_R;
    end else if (preempt_i && (state_q == ST_ALL_RED) && tick_wrap && (remain_q == ONE_R)) begin
      state_n   = ST_GREEN;
      phase_n   = preempt_phase_i;
      remain_n  = ZERO_R;
      elapsed_n = ZERO_R;
    end else if (pre_fall && (state_q == ST_GREEN)) begin
      remain_n  = MIN_R;
      elapsed_n = ZERO_R;
    end else begin
      remain_n  = remain_n;
    end
`endif
  end

  // Sticky demand latch: the serving phase ignores its detector, entry to green clears.
  always_comb begin
    green_mask = (state_q == ST_GREEN) ? phase_onehot(phase_q) : 4'b0000;
    clear_mask = ((state_n == ST_GREEN) && (state_q != ST_GREEN)) ? phase_onehot(phase_n) : 4'b0000;
    demand_n   = (demand_q | (demand_i & ~green_mask)) & ~clear_mask;
  end

  // State, countdown, demand and lamp registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_EW_LEFT;
      remain_q  <= ZERO_R;
      elapsed_q <= ZERO_R;
      demand_q  <= 4'b0000;
      green_q   <= 4'b0000;
      yellow_q  <= 4'b0000;
`ifdef TL_PREEMPT_EN
      pre_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      phase_q   <= phase_n;
      remain_q  <= remain_n;
      elapsed_q <= elapsed_n;
      demand_q  <= demand_n;
      green_q   <= (state_n == ST_GREEN)  ? phase_onehot(phase_n) : 4'b0000;
      yellow_q  <= (state_n == ST_YELLOW) ? phase_onehot(phase_n) : 4'b0000;
`ifdef TL_PREEMPT_EN
      pre_q     <= preempt_i;
`endif
    end
  end

  assign green_o     = green_q;
  assign yellow_o    = yellow_q;
  assign state_o     = state_q;
  assign cur_phase_o = phase_q;
  assign remain_o    = remain_q;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed scoreboard bench for tl_phase_scheduler with a short tick period.
module tb_tl_phase_scheduler;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] demand_i;
  logic [3:0] green_o;
  logic [3:0] yellow_o;
  logic [1:0] state_o;
  logic [1:0] cur_phase_o;
  logic [6:0] remain_o;
  logic       tick_o;
`ifdef TL_PREEMPT_EN
  logic       preempt_i;
  logic [1:0] preempt_phase_i;
`endif

  int checks = 0;
  int errors = 0;
  int last_gap = 0;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] ph;
    logic [6:0] rem;
  } exp_t;

  exp_t sb[$];

  tl_phase_scheduler #(
    .TICK_DIV(4), .MIN_GREEN(3), .MAX_GREEN(6), .EXT(2), .YELLOW(2), .ALL_RED(1)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .demand_i        (demand_i),
`ifdef TL_PREEMPT_EN
    .preempt_i       (preempt_i),
    .preempt_phase_i (preempt_phase_i),
`endif
    .green_o         (green_o),
    .yellow_o        (yellow_o),
    .state_o         (state_o),
    .cur_phase_o     (cur_phase_o),
    .remain_o        (remain_o),
    .tick_o          (tick_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic cmp(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [1:0] ph, input logic [6:0] rem);
    exp_t e;
    e.st  = st;
    e.ph  = ph;
    e.rem = rem;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    logic [3:0] eg;
    logic [3:0] ey;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e  = sb.pop_front();
      eg = (e.st == 2'd1) ? (4'b0001 << e.ph) : 4'b0000;
      ey = (e.st == 2'd2) ? (4'b0001 << e.ph) : 4'b0000;
      cmp({tag, ".state"},  7'(state_o),     7'(e.st));
      cmp({tag, ".phase"},  7'(cur_phase_o), 7'(e.ph));
      cmp({tag, ".remain"}, remain_o,        e.rem);
      cmp({tag, ".green"},  7'(green_o),     7'(eg));
      cmp({tag, ".yellow"}, 7'(yellow_o),    7'(ey));
    end
  endtask

  task automatic wait_tick(input string tag);
    bit got = 1'b0;
    last_gap = 0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge sys_clk);
      last_gap++;
      if (tick_o === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s tick timeout observed=none expected=tick", tag);
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st);
    bit got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge sys_clk);
      if (state_o === st) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s state timeout observed=%0d expected=%0d", tag, state_o, st);
    end
  endtask

  // Expect a snapshot at the next tick.
  task automatic texp(input string tag, input logic [1:0] st, input logic [1:0] ph, input logic [6:0] rem);
    push_exp(st, ph, rem);
    wait_tick(tag);
    check_out(tag);
  endtask

  // Expect a snapshot once the given state is reached.
  task automatic sexp(input string tag, input logic [1:0] st, input logic [1:0] ph, input logic [6:0] rem);
    push_exp(st, ph, rem);
    wait_state(tag, st);
    check_out(tag);
  endtask

  task automatic pulse(input logic [3:0] d, input logic [3:0] after);
    demand_i = d;
    @(negedge sys_clk);
    demand_i = after;
  endtask

  // Directed sequence.
  initial begin
    sys_rst  = 1'b1;
    demand_i = 4'hF;
`ifdef TL_PREEMPT_EN
    preempt_i       = 1'b0;
    preempt_phase_i = 2'd0;
`endif
    repeat (3) @(negedge sys_clk);
    push_exp(2'd0, 2'd3, 7'd0);
    check_out("reset");
    cmp("reset.tick", 7'(tick_o), 7'd0);

    // Two requests from IDLE: phase 0 first, then phase 2; bit0 must not linger.
    sys_rst = 1'b0;
    pulse(4'b0101, 4'b0000);
    sexp("A.enter0", 2'd1, 2'd0, 7'd3);
    texp("A.t1",     2'd1, 2'd0, 7'd2);
    texp("A.t2",     2'd1, 2'd0, 7'd1);
    cmp("A.tick_period", 7'(last_gap), 7'd4);
    texp("A.yel",    2'd2, 2'd0, 7'd2);
    texp("A.yel2",   2'd2, 2'd0, 7'd1);
    texp("A.allred", 2'd3, 2'd0, 7'd1);
    texp("A.idle",   2'd0, 2'd0, 7'd0);
    sexp("A.enter2", 2'd1, 2'd2, 7'd3);
    texp("A.p2t1",   2'd1, 2'd2, 7'd2);
    texp("A.p2t2",   2'd1, 2'd2, 7'd1);
    texp("A.rest",   2'd1, 2'd2, 7'd0);
    texp("A.rest2",  2'd1, 2'd2, 7'd0);

    // Rest leaves on demand; phase 0 held demand maxes out after 6 ticks.
    pulse(4'b0011, 4'b0001);
    texp("B.yel2",   2'd2, 2'd2, 7'd2);
    texp("B.yel2b",  2'd2, 2'd2, 7'd1);
    texp("B.ar2",    2'd3, 2'd2, 7'd1);
    texp("B.idle",   2'd0, 2'd2, 7'd0);
    sexp("B.enter0", 2'd1, 2'd0, 7'd3);
    texp("B.g1",     2'd1, 2'd0, 7'd2);
    texp("B.g2",     2'd1, 2'd0, 7'd2);
    texp("B.g3",     2'd1, 2'd0, 7'd2);
    texp("B.g4",     2'd1, 2'd0, 7'd2);
    texp("B.g5",     2'd1, 2'd0, 7'd2);
    texp("B.maxout", 2'd2, 2'd0, 7'd2);
    demand_i = 4'b0000;
    texp("B.yel0b",  2'd2, 2'd0, 7'd1);
    texp("B.ar0",    2'd3, 2'd0, 7'd1);
    texp("B.idle0",  2'd0, 2'd0, 7'd0);
    sexp("B.enter1", 2'd1, 2'd1, 7'd3);

    // Phase 1 yields to phase 0; phase 0 gets one extension tick.
    texp("C.p1t1",   2'd1, 2'd1, 7'd2);
    pulse(4'b0001, 4'b0000);
    texp("C.p1t2",   2'd1, 2'd1, 7'd1);
    texp("C.p1yel",  2'd2, 2'd1, 7'd2);
    texp("C.p1yel2", 2'd2, 2'd1, 7'd1);
    texp("C.p1ar",   2'd3, 2'd1, 7'd1);
    texp("C.idle",   2'd0, 2'd1, 7'd0);
    sexp("C.enter0", 2'd1, 2'd0, 7'd3);
    texp("C.t1",     2'd1, 2'd0, 7'd2);
    pulse(4'b0011, 4'b0001);
    texp("C.ext",    2'd1, 2'd0, 7'd2);
    demand_i = 4'b0000;
    texp("C.t3",     2'd1, 2'd0, 7'd1);
    texp("C.yel",    2'd2, 2'd0, 7'd2);

    // Reset asserted mid-yellow clears outputs without a clock edge.
    #1 sys_rst = 1'b1;
    #1;
    push_exp(2'd0, 2'd3, 7'd0);
    check_out("R.async");
    cmp("R.async.tick", 7'(tick_o), 7'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

`ifdef TL_PREEMPT_EN
    pulse(4'b0001, 4'b0000);
    sexp("P.enter0", 2'd1, 2'd0, 7'd3);
    texp("P.t1",     2'd1, 2'd0, 7'd2);
    preempt_i       = 1'b1;
    preempt_phase_i = 2'd3;
    @(negedge sys_clk);
    push_exp(2'd2, 2'd0, 7'd2);
    check_out("P.force");
    texp("P.yel2",   2'd2, 2'd0, 7'd1);
    texp("P.ar",     2'd3, 2'd0, 7'd1);
    texp("P.green3", 2'd1, 2'd3, 7'd0);
    texp("P.hold",   2'd1, 2'd3, 7'd0);
    preempt_i = 1'b0;
    @(negedge sys_clk);
    push_exp(2'd1, 2'd3, 7'd3);
    check_out("P.release");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
